// File: rtl/retry_queue_pkg.sv
// Shared retry-path types: packet layout, request encoding, priorities and FSM states.
package retry_queue_pkg;

    localparam int unsigned REQ_W  = 3;
    localparam int unsigned PRIO_W = 2;
    localparam int unsigned BK_W   = 4;
    localparam int unsigned ROW_W  = 14;

    // Request encoding; anything above REQ_WRITE is an AiM command.
    localparam logic [REQ_W-1:0] REQ_READ    = 3'd0;
    localparam logic [REQ_W-1:0] REQ_WRITE   = 3'd1;
    localparam logic [REQ_W-1:0] REQ_AIM_MAC = 3'd4;
    localparam logic [REQ_W-1:0] REQ_AIM_ACT = 3'd5;

    localparam logic [PRIO_W-1:0] PRIO_LO = 2'd0;
    localparam logic [PRIO_W-1:0] PRIO_HI = 2'd3;

    typedef struct packed {
        logic [REQ_W-1:0]  req_type;
        logic [PRIO_W-1:0] prio;
        logic [BK_W-1:0]   bk_addr;
        logic [ROW_W-1:0]  row_addr;
    } pkt_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } retry_state_t;

endpackage

// File: rtl/retry_queue_if.sv
// Handshake bundle between data handler, retry queue and entry buffer.
interface retry_queue_if;
    import retry_queue_pkg::*;

    pkt_t fail_pkt;
    logic fail_valid;
    logic fail_rdy;
    pkt_t intf_pkt;
    logic intf_pkt_retry;
    logic intf_pkt_ack;

    modport slave (
        input  fail_pkt, fail_valid, intf_pkt_ack,
        output fail_rdy, intf_pkt, intf_pkt_retry
    );

    modport master (
        output fail_pkt, fail_valid, intf_pkt_ack,
        input  fail_rdy, intf_pkt, intf_pkt_retry
    );
endinterface

// File: rtl/retry_fifo.sv
// In-order circular buffer of rejected packets with registered occupancy.
module retry_fifo
    import retry_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  pkt_t                       push_pkt,
    input  logic                       pop,
    output pkt_t                       head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    pkt_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage write; contents need no reset since count gates the head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_pkt;
    end

    // Pointers wrap naturally; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;
    assign full = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/retry_queue.sv
// Re-issues rejected packets to the entry buffer, waiting for ack with timeout and inter-retry gap.
module retry_queue
    import retry_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned GAP         = 2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    retry_queue_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic [7:0]                 tout_cnt,
    output logic                       ovf_err,
    output logic                       proto_err
);
    localparam int unsigned WCNT_W = $clog2(ACK_TIMEOUT+1);
    localparam int unsigned GCNT_W = (GAP > 0) ? $clog2(GAP+1) : 1;

    retry_state_t      state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [GCNT_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [7:0]        tout_cnt_nxt;
    logic              ovf_err_nxt;
    logic              proto_err_nxt;
    logic              full;
    logic              push_c;
    logic              pop_c;
    pkt_t              head_c;

    // Space is judged on the registered count only; a same-cycle pop does not help.
    assign bus.fail_rdy       = !rst && !full;
    assign push_c             = bus.fail_valid && bus.fail_rdy;
    assign bus.intf_pkt       = head_c;
    assign bus.intf_pkt_retry = (state == S_ISSUE);

    retry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_c),
        .push_pkt (bus.fail_pkt),
        .pop      (pop_c),
        .head     (head_c),
        .count    (q_count),
        .full     (full)
    );

    // State, timers and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            gap_cnt   <= '0;
            tout_cnt  <= '0;
            ovf_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            tout_cnt  <= tout_cnt_nxt;
            ovf_err   <= ovf_err_nxt;
            proto_err <= proto_err_nxt;
        end
    end

    // Next-state: issue head, wait for ack or time out, then hold off for GAP cycles.
    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        gap_cnt_nxt   = gap_cnt;
        tout_cnt_nxt  = tout_cnt;
        ovf_err_nxt   = ovf_err || (bus.fail_valid && !bus.fail_rdy);
        proto_err_nxt = proto_err;
        pop_c         = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.intf_pkt_ack) proto_err_nxt = 1'b1;
                if (q_count != '0) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.intf_pkt_ack) proto_err_nxt = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.intf_pkt_ack) begin
                    pop_c = 1'b1;
                    if (GAP == 0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt   = S_GAP;
                        gap_cnt_nxt = GCNT_W'(GAP);
                    end
                end else if (wait_cnt == WCNT_W'(ACK_TIMEOUT - 1)) begin
                    state_nxt = S_ISSUE;
                    if (tout_cnt != 8'hFF) tout_cnt_nxt = tout_cnt + 8'd1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                end
            end
            S_GAP: begin
                if (bus.intf_pkt_ack) proto_err_nxt = 1'b1;
                if (gap_cnt <= GCNT_W'(1)) state_nxt = S_IDLE;
                else                       gap_cnt_nxt = gap_cnt - GCNT_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_retry_queue.sv
// Directed self-checking bench for retry_queue (DEPTH 8, GAP 2, ACK_TIMEOUT 16).
module tb_retry_queue;
    import retry_queue_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] q_count;
    logic [7:0] tout_cnt;
    logic       ovf_err;
    logic       proto_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    retry_queue_if bus();

    retry_queue #(.DEPTH(8), .GAP(2), .ACK_TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .q_count   (q_count),
        .tout_cnt  (tout_cnt),
        .ovf_err   (ovf_err),
        .proto_err (proto_err)
    );

    function automatic pkt_t mk_pkt(input logic [REQ_W-1:0] req, input logic [PRIO_W-1:0] prio,
                                    input logic [BK_W-1:0] bk, input logic [ROW_W-1:0] row);
        pkt_t p;
        p.req_type = req;
        p.prio     = prio;
        p.bk_addr  = bk;
        p.row_addr = row;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fail_valid   = 1'b0;
        bus.fail_pkt     = '0;
        bus.intf_pkt_ack = 1'b0;
        #12;
        checks++; if (bus.fail_rdy !== 1'b0) begin failures++; $display("FAIL reset_fail_rdy got=%0b exp=0", bus.fail_rdy); end
        checks++; if (bus.intf_pkt_retry !== 1'b0) begin failures++; $display("FAIL reset_retry got=%0b exp=0", bus.intf_pkt_retry); end
        checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL reset_q_count got=%0d exp=0", q_count); end
        checks++; if (bus.intf_pkt !== pkt_t'('0)) begin failures++; $display("FAIL reset_intf_pkt got=%0h exp=0", bus.intf_pkt); end
        checks++; if ({tout_cnt, ovf_err, proto_err} !== 10'd0) begin failures++; $display("FAIL reset_status got=%0h/%0b/%0b exp=0/0/0", tout_cnt, ovf_err, proto_err); end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.fail_rdy !== 1'b1) begin failures++; $display("FAIL post_reset_fail_rdy got=%0b exp=1", bus.fail_rdy); end
        tick();
    endtask

    task automatic test_single();
        pkt_t p = mk_pkt(REQ_READ, PRIO_LO, 4'd3, 14'h1A);
        int bad = 0;
        bus.fail_pkt   = p;
        bus.fail_valid = 1'b1;
        tick();
        bus.fail_valid = 1'b0;
        checks++; if (q_count !== 4'd1) begin failures++; $display("FAIL single_q_count_after_push got=%0d exp=1", q_count); end
        if (bus.intf_pkt_retry !== 1'b0) bad++;
        for (int k = 2; k <= 6; k++) begin
            tick();
            bus.intf_pkt_ack = (k == 3);
            if (bus.intf_pkt_retry !== (k == 2)) bad++;
            if (k == 2) begin
                checks++; if (bus.intf_pkt !== p) begin failures++; $display("FAIL single_pkt got=%0h exp=%0h", bus.intf_pkt, p); end
            end
            if (k == 4) begin
                checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL single_q_count_after_ack got=%0d exp=0", q_count); end
            end
        end
        bus.intf_pkt_ack = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL single_pulse_timing bad_cycles=%0d exp=0", bad); end
        tick();
    endtask

    task automatic test_timeout();
        pkt_t p = mk_pkt(REQ_WRITE, PRIO_HI, 4'd5, 14'h2B3);
        int extra = 0;
        bus.fail_pkt   = p;
        bus.fail_valid = 1'b1;
        tick();
        bus.fail_valid = 1'b0;
        tick();
        checks++; if (bus.intf_pkt_retry !== 1'b1) begin failures++; $display("FAIL timeout_first_pulse got=%0b exp=1", bus.intf_pkt_retry); end
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (bus.intf_pkt_retry) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL timeout_early_pulse got=%0d exp=0", extra); end
        tick();
        checks++; if (bus.intf_pkt_retry !== 1'b1) begin failures++; $display("FAIL timeout_repulse got=%0b exp=1", bus.intf_pkt_retry); end
        checks++; if (bus.intf_pkt !== p) begin failures++; $display("FAIL timeout_pkt got=%0h exp=%0h", bus.intf_pkt, p); end
        checks++; if (tout_cnt !== 8'd1) begin failures++; $display("FAIL timeout_tout_cnt got=%0d exp=1", tout_cnt); end
        tick();
        bus.intf_pkt_ack = 1'b1;
        tick();
        bus.intf_pkt_ack = 1'b0;
        checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL timeout_pop got=%0d exp=0", q_count); end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        pkt_t pk [3];
        int bad = 0;
        pk[0] = mk_pkt(REQ_READ,    PRIO_LO, 4'd1, 14'h0101);
        pk[1] = mk_pkt(REQ_AIM_MAC, PRIO_HI, 4'd2, 14'h0202);
        pk[2] = mk_pkt(REQ_WRITE,   PRIO_LO, 4'd7, 14'h3FFF);
        bus.fail_pkt = pk[0]; bus.fail_valid = 1'b1;
        tick();
        bus.fail_pkt = pk[1];
        tick();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            bus.fail_pkt     = pk[2];
            bus.fail_valid   = (k == 0);
            bus.intf_pkt_ack = (k == 1) || (k == 6) || (k == 11);
            if (bus.intf_pkt_retry !== ((k == 0) || (k == 5) || (k == 10))) bad++;
            if (k % 5 == 0 && k <= 10) begin
                checks++; if (bus.intf_pkt !== pk[k/5]) begin failures++; $display("FAIL b2b_pkt%0d got=%0h exp=%0h", k/5, bus.intf_pkt, pk[k/5]); end
            end
        end
        bus.intf_pkt_ack = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_pulse_spacing bad_cycles=%0d exp=0", bad); end
        checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL b2b_final_q_count got=%0d exp=0", q_count); end
        repeat (3) tick();
    endtask

    task automatic test_overflow();
        pkt_t pk [9];
        for (int i = 0; i < 9; i++)
            pk[i] = mk_pkt((i % 3 == 0) ? REQ_AIM_ACT : ((i % 3 == 1) ? REQ_READ : REQ_AIM_MAC),
                           PRIO_W'(i), BK_W'(i + 8), ROW_W'(16'h0A00 + i));
        checks++; if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_before got=%0b exp=0", ovf_err); end
        for (int i = 0; i < 9; i++) begin
            bus.fail_pkt   = pk[i];
            bus.fail_valid = 1'b1;
            if (i == 8) begin
                checks++; if (bus.fail_rdy !== 1'b0) begin failures++; $display("FAIL ovf_fail_rdy got=%0b exp=0", bus.fail_rdy); end
                checks++; if (q_count !== 4'd8) begin failures++; $display("FAIL ovf_q_count_full got=%0d exp=8", q_count); end
            end
            tick();
        end
        bus.fail_valid = 1'b0;
        checks++; if (ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_err got=%0b exp=1", ovf_err); end
        checks++; if (q_count !== 4'd8) begin failures++; $display("FAIL ovf_q_count_after got=%0d exp=8", q_count); end
        for (int j = 0; j < 8; j++) begin
            bit found = 1'b0;
            for (int w = 0; w < 40 && !found; w++) begin
                if (bus.intf_pkt_retry) found = 1'b1;
                else tick();
            end
            checks++; if (!found) begin failures++; $display("FAIL ovf_drain_no_pulse entry=%0d got=none exp=pulse", j); end
            checks++; if (bus.intf_pkt !== pk[j]) begin failures++; $display("FAIL ovf_drain_order entry=%0d got=%0h exp=%0h", j, bus.intf_pkt, pk[j]); end
            tick();
            bus.intf_pkt_ack = 1'b1;
            tick();
            bus.intf_pkt_ack = 1'b0;
        end
        checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL ovf_drained got=%0d exp=0", q_count); end
        repeat (4) tick();
    endtask

    task automatic test_proto();
        pkt_t p = mk_pkt(REQ_READ, PRIO_HI, 4'd9, 14'h0777);
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_before got=%0b exp=0", proto_err); end
        bus.fail_pkt   = p;
        bus.fail_valid = 1'b1;
        tick();
        bus.fail_valid   = 1'b0;
        bus.intf_pkt_ack = 1'b1;
        tick();
        bus.intf_pkt_ack = 1'b0;
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_err got=%0b exp=1", proto_err); end
        checks++; if (q_count !== 4'd1) begin failures++; $display("FAIL proto_no_pop got=%0d exp=1", q_count); end
        checks++; if (bus.intf_pkt_retry !== 1'b1 || bus.intf_pkt !== p) begin failures++; $display("FAIL proto_pulse got=%0b/%0h exp=1/%0h", bus.intf_pkt_retry, bus.intf_pkt, p); end
        tick();
        bus.intf_pkt_ack = 1'b1;
        tick();
        bus.intf_pkt_ack = 1'b0;
        checks++; if (q_count !== 4'd0) begin failures++; $display("FAIL proto_pop got=%0d exp=0", q_count); end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            bus.fail_pkt   = mk_pkt(REQ_WRITE, PRIO_LO, BK_W'(i), ROW_W'(i * 3));
            bus.fail_valid = 1'b1;
            tick();
        end
        bus.fail_valid = 1'b0;
        checks++; if (q_count !== 4'd4) begin failures++; $display("FAIL rmid_q_count_before got=%0d exp=4", q_count); end
        rst = 1'b1;
        #1;
        checks++; if (bus.intf_pkt_retry !== 1'b0 || q_count !== 4'd0 || bus.fail_rdy !== 1'b0) begin failures++; $display("FAIL rmid_flush got=%0b/%0d/%0b exp=0/0/0", bus.intf_pkt_retry, q_count, bus.fail_rdy); end
        checks++; if ({tout_cnt, ovf_err, proto_err} !== 10'd0) begin failures++; $display("FAIL rmid_status got=%0h/%0b/%0b exp=0/0/0", tout_cnt, ovf_err, proto_err); end
        tick();
        tick();
        checks++; if (bus.fail_rdy !== 1'b0) begin failures++; $display("FAIL rmid_fail_rdy_held got=%0b exp=0", bus.fail_rdy); end
        rst = 1'b0;
        #1;
        checks++; if (bus.fail_rdy !== 1'b1) begin failures++; $display("FAIL rmid_fail_rdy_release got=%0b exp=1", bus.fail_rdy); end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.intf_pkt_retry) pulses++;
        end
        checks++; if (pulses !== 0 || q_count !== 4'd0) begin failures++; $display("FAIL rmid_quiet got=%0d/%0d exp=0/0", pulses, q_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_back_to_back();
        test_overflow();
        test_proto();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
